// File: rtl/trap_csr.sv
// Machine-mode trap controller: sequences exception entry and return, and holds the trap CSRs.
// Optional feature: define TRAP_MTVAL_EN to implement the mtval register (0x343).
module trap_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h00000004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_addr,
  output logic        exc_ready,
  input  logic        mret_valid,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        in_trap
);

  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_TRAPCNT = 12'h7C0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        w_accept;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_trapcnt;
  logic        w_unused;

  assign w_accept = exc_valid && exc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A new exception wins over mret in HANDLER, giving a nested entry instead of a return.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = ENTER;
      end
      ENTER: begin
        w_nextState = HANDLER;
      end
      HANDLER: begin
        if (w_accept) begin
          w_nextState = ENTER;
        end else if (mret_valid) begin
          w_nextState = RETURN;
        end
      end
      RETURN: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    exc_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    in_trap        = 1'b0;
    case (r_state)
      IDLE: begin
        exc_ready = 1'b1;
      end
      ENTER: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_mtvec;
      end
      HANDLER: begin
        exc_ready = 1'b1;
        in_trap   = 1'b1;
      end
      RETURN: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_mepc;
      end
      default: begin
        exc_ready = 1'b0;
      end
    endcase
    flush = redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec <= RESET_MTVEC;
    end else if (csr_we && (csr_addr == ADDR_MTVEC)) begin
      r_mtvec <= {csr_wdata[31:2], 2'b00};
    end
  end

  // Exception capture takes precedence over a software write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
    end else if (w_accept) begin
      r_mepc   <= {exc_pc[31:2], 2'b00};
      r_mcause <= exc_code;
    end else if (csr_we) begin
      if (csr_addr == ADDR_MEPC)   r_mepc   <= {csr_wdata[31:2], 2'b00};
      if (csr_addr == ADDR_MCAUSE) r_mcause <= csr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trapcnt <= 32'h0;
    end else if (w_accept && (r_trapcnt != 32'hFFFFFFFF)) begin
      r_trapcnt <= r_trapcnt + 32'd1;
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [31:0] r_mtval;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtval <= 32'h0;
    end else if (w_accept) begin
      r_mtval <= exc_addr;
    end else if (csr_we && (csr_addr == ADDR_MTVAL)) begin
      r_mtval <= csr_wdata;
    end
  end

  assign w_unused = ^exc_pc[1:0];
`else
  // Without mtval the faulting address has no destination.
  assign w_unused = ^{exc_pc[1:0], exc_addr};
`endif

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_MTVEC:   csr_rdata = r_mtvec;
      ADDR_MEPC:    csr_rdata = r_mepc;
      ADDR_MCAUSE:  csr_rdata = r_mcause;
`ifdef TRAP_MTVAL_EN
      ADDR_MTVAL:   csr_rdata = r_mtval;
`else
      ADDR_MTVAL:   csr_rdata = 32'h0;
`endif
      ADDR_TRAPCNT: csr_rdata = r_trapcnt;
      default:      csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_trap_csr.sv
// Directed, table-driven bench for trap_csr in its default build (mtval omitted).
module tb_trap_csr;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_addr;
  logic        exc_ready;
  logic        mret_valid;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        in_trap;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        mret;
    logic        we;
    logic [11:0] caddr;
    logic [31:0] wdata;
    logic        eReady;
    logic        eRv;
    logic [31:0] ePc;
    logic        eFlush;
    logic        eTrap;
    logic [31:0] eRdata;
  } vec_t;

  vec_t vecs[$];

  trap_csr dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_addr       (exc_addr),
    .exc_ready      (exc_ready),
    .mret_valid     (mret_valid),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .in_trap        (in_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic ev, input logic [31:0] code,
                        input logic [31:0] pc, input logic [31:0] addr, input logic mret,
                        input logic we, input logic [11:0] caddr, input logic [31:0] wdata,
                        input logic eReady, input logic eRv, input logic [31:0] ePc,
                        input logic eTrap, input logic [31:0] eRdata);
    vec_t v;
    v.rst = r; v.ev = ev; v.code = code; v.pc = pc; v.addr = addr; v.mret = mret;
    v.we = we; v.caddr = caddr; v.wdata = wdata;
    v.eReady = eReady; v.eRv = eRv; v.ePc = ePc; v.eFlush = eRv; v.eTrap = eTrap;
    v.eRdata = eRdata;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge; outputs settle before the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    exc_valid  = v.ev;
    exc_code   = v.code;
    exc_pc     = v.pc;
    exc_addr   = v.addr;
    mret_valid = v.mret;
    csr_we     = v.we;
    csr_addr   = v.caddr;
    csr_wdata  = v.wdata;
    #1;
  endtask

  task automatic idleInputs();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    csr_we     = 1'b0;
  endtask

  initial begin
    int waited;
    checks   = 0;
    failures = 0;
    rst = 1'b1; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_addr = '0;
    mret_valid = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    repeat (2) @(posedge clk);

    //     rst ev code    pc      addr    mret we caddr   wdata     rdy rv rpc      trap rdata
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h305, 32'h0,    1, 0, 32'h0,    0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h341, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h342, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 1, 32'h2, 32'h102, 32'hDEAD, 0, 0, 12'h343, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h341, 32'h0,    0, 1, 32'h4,    0, 32'h100);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h342, 32'h0,    1, 0, 32'h0,    1, 32'h2);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    1, 32'h1);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h343, 32'h0,    1, 0, 32'h0,    1, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    1, 0, 12'h341, 32'h0,    1, 0, 32'h0,    1, 32'h100);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h305, 32'h0,    0, 1, 32'h100,  0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    1, 0, 12'h305, 32'h0,    1, 0, 32'h0,    0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 1, 12'h305, 32'h2003, 1, 0, 32'h0,    0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h305, 32'h0,    1, 0, 32'h0,    0, 32'h2000);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 1, 12'h7C0, 32'h55,   1, 0, 32'h0,    0, 32'h1);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 1, 12'h123, 32'hFFFF, 1, 0, 32'h0,    0, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    0, 32'h1);
    addVec(0, 1, 32'h5, 32'h30,  32'h0,    0, 1, 12'h341, 32'h888,  1, 0, 32'h0,    0, 32'h100);
    addVec(0, 1, 32'h7, 32'h400, 32'h0,    0, 0, 12'h341, 32'h0,    0, 1, 32'h2000, 0, 32'h30);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h342, 32'h0,    1, 0, 32'h0,    1, 32'h5);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    1, 32'h2);
    addVec(0, 1, 32'h3, 32'h200, 32'h0,    1, 0, 12'h341, 32'h0,    1, 0, 32'h0,    1, 32'h30);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h341, 32'h0,    0, 1, 32'h2000, 0, 32'h200);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    1, 32'h3);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 1, 12'h342, 32'hABC,  1, 0, 32'h0,    1, 32'h3);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h342, 32'h0,    1, 0, 32'h0,    1, 32'hABC);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 1, 12'h341, 32'h123,  1, 0, 32'h0,    1, 32'h200);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    1, 0, 12'h341, 32'h0,    1, 0, 32'h0,    1, 32'h120);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h341, 32'h0,    0, 1, 32'h120,  0, 32'h120);
    addVec(0, 1, 32'h1, 32'h10,  32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    0, 32'h3);
    addVec(1, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    0, 1, 32'h2000, 0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h305, 32'h0,    1, 0, 32'h0,    0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h7C0, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h341, 32'h0,    1, 0, 32'h0,    0, 32'h0);
    addVec(0, 1, 32'h9, 32'h44,  32'h0,    0, 1, 12'h305, 32'h3000, 1, 0, 32'h0,    0, 32'h4);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h305, 32'h0,    0, 1, 32'h3000, 0, 32'h3000);
    addVec(0, 0, 32'h0, 32'h0,   32'h0,    0, 0, 12'h342, 32'h0,    1, 0, 32'h0,    1, 32'h9);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d exc_ready", i), {31'h0, exc_ready}, {31'h0, vecs[i].eReady});
      checkOutput($sformatf("v%0d redirect_valid", i), {31'h0, redirect_valid}, {31'h0, vecs[i].eRv});
      checkOutput($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].ePc);
      checkOutput($sformatf("v%0d flush", i), {31'h0, flush}, {31'h0, vecs[i].eFlush});
      checkOutput($sformatf("v%0d in_trap", i), {31'h0, in_trap}, {31'h0, vecs[i].eTrap});
      checkOutput($sformatf("v%0d csr_rdata", i), csr_rdata, vecs[i].eRdata);
    end

    // Handler is active: return and confirm the redirect is a single-cycle pulse to mepc.
    @(negedge clk);
    idleInputs();
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
    waited = 0;
    while (!redirect_valid && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("mret redirect seen", {31'h0, redirect_valid}, 32'h1);
    checkOutput("mret redirect_pc", redirect_pc, 32'h44);
    @(negedge clk);
    checkOutput("mret pulse width", {31'h0, redirect_valid}, 32'h0);
    checkOutput("mret idle pc", redirect_pc, 32'h0);
    checkOutput("mret idle ready", {31'h0, exc_ready}, 32'h1);
    checkOutput("mret idle in_trap", {31'h0, in_trap}, 32'h0);

    // Reset during RETURN must swallow the pending redirect.
    exc_valid = 1'b1; exc_pc = 32'h80; exc_code = 32'h4;
    @(negedge clk);
    exc_valid = 1'b0;
    @(negedge clk);
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
    checkOutput("pre-reset return", {31'h0, redirect_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset drops return", {31'h0, redirect_valid}, 32'h0);
    @(negedge clk);
    checkOutput("no pulse after release", {31'h0, redirect_valid}, 32'h0);
    checkOutput("ready after release", {31'h0, exc_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
